// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: constants and types shared by the instruction-memory
// responder and the fetch stage.
//   IMEM_NOP      - canonical NOP (addi x0,x0,0) returned on faults / after reset
//   imem_state_e  - responder FSM encoding
//   pc_fault()    - misaligned or out-of-range PC check
package imem_responder_pkg;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_BUSY = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    // A PC faults when it is not word aligned or addresses beyond the RAM.
    function automatic logic pc_fault(input logic [31:0] pc, input int depth_log2);
        logic [31:0] hi_mask;
        hi_mask = ~((32'h1 << (depth_log2 + 2)) - 32'h1);
        return (pc[1:0] != 2'b00) || ((pc & hi_mask) != 32'h0);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: word-wide RAM with one synchronous read port and an independent
// write port. A read and a write to the same word on the same edge returns
// the old contents (read-before-write). Contents are not reset.
// Ports:
//   clk      - clock, rising edge
//   we_i     - write enable;  waddr_i / wdata_i - write word address / data
//   re_i     - read enable;   raddr_i - read word address
//   rdata_o  - registered read data, holds while re_i is low
module imem_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder at the far end of the fetch
// interface. Accepts a PC in IDLE, waits WAIT_STATES cycles in BUSY (stall
// raised), then in RESP reads the word; Valid_o pulses the following cycle.
// Flush_i aborts an outstanding fetch. A backdoor port fills the RAM.
// Ports:
//   Clk, Reset_n           - clock (rising), async active-low reset
//   Req_i, Pc_i, Flush_i   - fetch request, byte PC, redirect/abort
//   Instruction_o          - returned word, held between responses
//   Valid_o, Fault_o       - one-cycle response / fault pulses
//   Stall_if_o             - high while in BUSY
//   Load_we_i/addr_i/data_i - backdoor RAM write
// Optional (macro IMEM_PERF_EN): Fetch_count_o, Wait_count_o, Flush_count_o.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] NOP_WORD    = IMEM_NOP
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Req_i,
    input  logic [31:0]           Pc_i,
    input  logic                  Flush_i,
    output logic [31:0]           Instruction_o,
    output logic                  Valid_o,
    output logic                  Stall_if_o,
    output logic                  Fault_o,
    input  logic                  Load_we_i,
    input  logic [DEPTH_LOG2-1:0] Load_addr_i,
    input  logic [31:0]           Load_data_i
`ifdef IMEM_PERF_EN
   ,output logic [31:0]           Fetch_count_o,
    output logic [31:0]           Wait_count_o,
    output logic [15:0]           Flush_count_o
`endif
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    imem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        nop_sel_q, nop_sel_d;   // Instruction_o shows NOP_WORD instead of RAM data
    logic        resp_fault;
    logic        ram_re;
    logic [31:0] ram_rdata;

    assign resp_fault = pc_fault(pc_q, DEPTH_LOG2);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        valid_d   = 1'b0;
        fault_d   = 1'b0;
        nop_sel_d = nop_sel_q;
        ram_re    = 1'b0;
        case (state_q)
            IMEM_IDLE: begin
                if (Req_i && !Flush_i) begin
                    pc_d    = Pc_i;
                    cnt_d   = WS;
                    state_d = (WAIT_STATES == 0) ? IMEM_RESP : IMEM_BUSY;
                end
            end
            IMEM_BUSY: begin
                if (Flush_i) begin
                    state_d = IMEM_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = IMEM_RESP;
                end
            end
            IMEM_RESP: begin
                state_d = IMEM_IDLE;
                // The RAM read register doubles as the instruction register;
                // on a fault it keeps its old data and the NOP select masks it.
                if (!Flush_i) begin
                    valid_d   = 1'b1;
                    fault_d   = resp_fault;
                    nop_sel_d = resp_fault;
                    ram_re    = !resp_fault;
                end
            end
            default: state_d = IMEM_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IMEM_IDLE;
            cnt_q     <= 4'd0;
            pc_q      <= 32'h0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            nop_sel_q <= nop_sel_d;
        end
    end

    imem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk     (Clk),
        .we_i    (Load_we_i),
        .waddr_i (Load_addr_i),
        .wdata_i (Load_data_i),
        .re_i    (ram_re),
        .raddr_i (pc_q[DEPTH_LOG2+1:2]),
        .rdata_o (ram_rdata)
    );

    assign Instruction_o = nop_sel_q ? NOP_WORD : ram_rdata;
    assign Valid_o       = valid_q;
    assign Fault_o       = fault_q;
    assign Stall_if_o    = (state_q == IMEM_BUSY);

`ifdef IMEM_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, valid_q};
        wait_cnt_d  = wait_cnt_q + {31'd0, Stall_if_o};
        flush_cnt_d = flush_cnt_q;
        if (Flush_i && (state_q == IMEM_BUSY || state_q == IMEM_RESP))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_cnt_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Fetch_count_o = fetch_cnt_q;
    assign Wait_count_o  = wait_cnt_q;
    assign Flush_count_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH_LOG2=10, WAIT_STATES=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_imem_responder;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req_i;
    logic [31:0] Pc_i;
    logic        Flush_i;
    logic [31:0] Instruction_o;
    logic        Valid_o, Stall_if_o, Fault_o;
    logic        Load_we_i;
    logic [9:0]  Load_addr_i;
    logic [31:0] Load_data_i;
`ifdef IMEM_PERF_EN
    logic [31:0] Fetch_count_o, Wait_count_o;
    logic [15:0] Flush_count_o;
`endif

    int errors = 0;
    int checks = 0;

    int          lat, sc;
    logic [31:0] ins;
    logic        flt;

    imem_responder dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Req_i         (Req_i),
        .Pc_i          (Pc_i),
        .Flush_i       (Flush_i),
        .Instruction_o (Instruction_o),
        .Valid_o       (Valid_o),
        .Stall_if_o    (Stall_if_o),
        .Fault_o       (Fault_o),
        .Load_we_i     (Load_we_i),
        .Load_addr_i   (Load_addr_i),
        .Load_data_i   (Load_data_i)
`ifdef IMEM_PERF_EN
       ,.Fetch_count_o (Fetch_count_o),
        .Wait_count_o  (Wait_count_o),
        .Flush_count_o (Flush_count_o)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        Load_we_i = 1'b1; Load_addr_i = a; Load_data_i = d;
        step();
        Load_we_i = 1'b0;
    endtask

    // Issue one request and wait (bounded) for Valid_o. Returns the number of
    // cycles from the accepting edge to Valid_o and the BUSY cycles seen.
    task automatic issue(input logic [31:0] pc, output int l, output int s,
                         output logic [31:0] i, output logic f);
        Req_i = 1'b1; Pc_i = pc;
        step();
        Req_i = 1'b0;
        l = 0; s = 0;
        while (!Valid_o && l < 20) begin
            if (Stall_if_o) s++;
            step();
            l++;
        end
        i = Instruction_o;
        f = Fault_o;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Req_i = 1'b0; Pc_i = 32'h0; Flush_i = 1'b0;
        Load_we_i = 1'b0; Load_addr_i = 10'h0; Load_data_i = 32'h0;
        repeat (2) step();
        checks++; if (Instruction_o !== 32'h00000013) begin errors++; $display("FAIL reset_instr: got %h want %h", Instruction_o, 32'h00000013); end
        checks++; if (Valid_o !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", Valid_o); end
        checks++; if (Stall_if_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall_if_o); end
        checks++; if (Fault_o !== 1'b0)    begin errors++; $display("FAIL reset_fault: got %b want 0", Fault_o); end
        Reset_n = 1'b1;
        step();
        checks++; if (Instruction_o !== 32'h00000013) begin errors++; $display("FAIL idle_instr: got %h want %h", Instruction_o, 32'h00000013); end
    endtask

    task automatic test_fetch();
        load(10'd0, 32'h00500093);
        load(10'd1, 32'h00A00113);
        load(10'd2, 32'h11112222);
        load(10'd3, 32'h00000013);
        issue(32'h0, lat, sc, ins, flt);
        checks++; if (lat !== 3) begin errors++; $display("FAIL fetch0_latency: got %0d want 3", lat); end
        checks++; if (sc !== 2)  begin errors++; $display("FAIL fetch0_stall_cycles: got %0d want 2", sc); end
        checks++; if (ins !== 32'h00500093) begin errors++; $display("FAIL fetch0_instr: got %h want %h", ins, 32'h00500093); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL fetch0_fault: got %b want 0", flt); end
        // back-to-back: request issued in the Valid_o cycle
        issue(32'h4, lat, sc, ins, flt);
        checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", lat); end
        checks++; if (ins !== 32'h00A00113) begin errors++; $display("FAIL b2b_instr: got %h want %h", ins, 32'h00A00113); end
        step();
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b want 0", Valid_o); end
        checks++; if (Instruction_o !== 32'h00A00113) begin errors++; $display("FAIL instr_hold: got %h want %h", Instruction_o, 32'h00A00113); end
        issue(32'h8, lat, sc, ins, flt);
        checks++; if (ins !== 32'h11112222) begin errors++; $display("FAIL fetch8_instr: got %h want %h", ins, 32'h11112222); end
    endtask

    task automatic test_fault();
        issue(32'h00000002, lat, sc, ins, flt);
        checks++; if (lat !== 3)   begin errors++; $display("FAIL mis_latency: got %0d want 3", lat); end
        checks++; if (sc !== 2)    begin errors++; $display("FAIL mis_stall_cycles: got %0d want 2", sc); end
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b want 1", flt); end
        checks++; if (ins !== 32'h00000013) begin errors++; $display("FAIL mis_instr: got %h want %h", ins, 32'h00000013); end
        step();
        checks++; if (Fault_o !== 1'b0) begin errors++; $display("FAIL fault_pulse: got %b want 0", Fault_o); end
        issue(32'h00001000, lat, sc, ins, flt);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL oor_fault: got %b want 1", flt); end
        checks++; if (ins !== 32'h00000013) begin errors++; $display("FAIL oor_instr: got %h want %h", ins, 32'h00000013); end
        issue(32'h80000000, lat, sc, ins, flt);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL hi_fault: got %b want 1", flt); end
        issue(32'h00000FFC, lat, sc, ins, flt);
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL last_word_fault: got %b want 0", flt); end
    endtask

    task automatic test_flush();
        issue(32'h4, lat, sc, ins, flt);           // Instruction_o = 00A00113
        // flush one cycle into BUSY
        Req_i = 1'b1; Pc_i = 32'h8;
        step();
        Req_i = 1'b0; Flush_i = 1'b1;
        checks++; if (Stall_if_o !== 1'b1) begin errors++; $display("FAIL flush_busy_stall: got %b want 1", Stall_if_o); end
        step();
        Flush_i = 1'b0;
        checks++; if (Stall_if_o !== 1'b0) begin errors++; $display("FAIL flush_busy_idle: got %b want 0", Stall_if_o); end
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL flush_busy_valid: got %b want 0", Valid_o); end
        checks++; if (Instruction_o !== 32'h00A00113) begin errors++; $display("FAIL flush_busy_hold: got %h want %h", Instruction_o, 32'h00A00113); end
        issue(32'h0, lat, sc, ins, flt);
        checks++; if (lat !== 3) begin errors++; $display("FAIL post_flush_latency: got %0d want 3", lat); end
        checks++; if (ins !== 32'h00500093) begin errors++; $display("FAIL post_flush_instr: got %h want %h", ins, 32'h00500093); end
        // flush during RESP
        Req_i = 1'b1; Pc_i = 32'h4;
        step();
        Req_i = 1'b0;
        step();
        step();
        Flush_i = 1'b1;                             // state is RESP now
        step();
        Flush_i = 1'b0;
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL flush_resp_valid: got %b want 0", Valid_o); end
        checks++; if (Instruction_o !== 32'h00500093) begin errors++; $display("FAIL flush_resp_hold: got %h want %h", Instruction_o, 32'h00500093); end
        // flush beats a request in IDLE
        Req_i = 1'b1; Flush_i = 1'b1; Pc_i = 32'h4;
        step();
        Req_i = 1'b0; Flush_i = 1'b0;
        checks++; if (Stall_if_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", Stall_if_o); end
        repeat (3) step();
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL flush_idle_valid: got %b want 0", Valid_o); end
    endtask

    task automatic test_reset_mid();
        issue(32'h4, lat, sc, ins, flt);           // Instruction_o = 00A00113
        Req_i = 1'b1; Pc_i = 32'h0;
        step();
        Req_i = 1'b0;
        checks++; if (Stall_if_o !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", Stall_if_o); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (Stall_if_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", Stall_if_o); end
        checks++; if (Instruction_o !== 32'h00000013) begin errors++; $display("FAIL rst_mid_instr: got %h want %h", Instruction_o, 32'h00000013); end
        step();
        step();
        Reset_n = 1'b1;
        checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_lost: got %b want 0", Valid_o); end
        step();
        issue(32'h4, lat, sc, ins, flt);
        checks++; if (ins !== 32'h00A00113) begin errors++; $display("FAIL rst_ram_kept: got %h want %h", ins, 32'h00A00113); end
    endtask

    task automatic test_rbw();
        Req_i = 1'b1; Pc_i = 32'hC;
        step();
        Req_i = 1'b0;
        step();
        step();
        // RESP cycle: write word 3 on the same edge that reads it
        Load_we_i = 1'b1; Load_addr_i = 10'd3; Load_data_i = 32'hDEADBEEF;
        step();
        Load_we_i = 1'b0;
        checks++; if (Valid_o !== 1'b1) begin errors++; $display("FAIL rbw_valid: got %b want 1", Valid_o); end
        checks++; if (Instruction_o !== 32'h00000013) begin errors++; $display("FAIL rbw_old: got %h want %h", Instruction_o, 32'h00000013); end
        checks++; if (Fault_o !== 1'b0) begin errors++; $display("FAIL rbw_fault: got %b want 0", Fault_o); end
        issue(32'hC, lat, sc, ins, flt);
        checks++; if (ins !== 32'hDEADBEEF) begin errors++; $display("FAIL rbw_new: got %h want %h", ins, 32'hDEADBEEF); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_fault();
        test_flush();
        test_reset_mid();
        test_rbw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface: accepts PC requests from the fetch stage and returns the 32-bit instruction word.
- Word-addressed RAM with programmable wait states.
- Raises a stall while a fetch is outstanding and supports flush on redirect.
- Backdoor load port fills the RAM from the testbench or boot loader. Replaces the externally driven instruction register.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words (1024 words = 4 KiB).
- WAIT_STATES, 2, extra cycles between request acceptance and response; range 0..15.
- NOP_WORD, 32'h00000013, word returned on a fault or before any valid response (addi x0,x0,0).

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Req_i  in  1  fetch request; sampled only in IDLE.
- Pc_i  in  32  byte address of the requested instruction.
- Flush_i  in  1  branch/jump redirect; aborts any outstanding fetch.
- Instruction_o  out  32  returned instruction; holds its value between responses.
- Valid_o  out  1  one-cycle pulse, Instruction_o is new this cycle.
- Stall_if_o  out  1  high while a fetch is outstanding (BUSY state).
- Fault_o  out  1  one-cycle pulse with Valid_o for a misaligned or out-of-range PC.
- Load_we_i  in  1  backdoor write enable.
- Load_addr_i  in  DEPTH_LOG2  backdoor word address.
- Load_data_i  in  32  backdoor write data.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, Instruction_o = NOP_WORD, Valid_o = 0, Stall_if_o = 0, Fault_o = 0, wait counter = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Req_i=1 and Flush_i=0: latch Pc_i, load the counter with WAIT_STATES, go to BUSY.
  - Exception: if WAIT_STATES=0, go directly to RESP.
  - Req_i=0: stay in IDLE.
- BUSY:
  - Stall_if_o=1.
  - Counter decrements each cycle; at counter==1, go to RESP on the next edge.
- RESP:
  - Instruction_o <= RAM[latched_pc[DEPTH_LOG2+1:2]], Valid_o=1 for one cycle, then IDLE.
  - Stall_if_o=0 in RESP.
- Latency: response is registered WAIT_STATES+1 cycles after the accepting edge.
- Back-to-back: a new request is accepted the cycle after RESP.
- Fault:
  - Condition: latched_pc[1:0]!=0 or any latched_pc[31:DEPTH_LOG2+2]!=0.
  - Response: Instruction_o=NOP_WORD, Valid_o=1, Fault_o=1 in RESP.
  - Wait states still apply.
- Flush_i in BUSY or RESP: go to IDLE next edge; no Valid_o, no Fault_o, Instruction_o unchanged.
- Flush_i overrides Req_i in IDLE.
- Load port:
  - Write occurs on any edge where Load_we_i=1, independent of FSM state.
  - Same-cycle write and RESP read of the same word returns the old data (read-before-write).
- Reset mid-fetch: immediate return to IDLE and reset values; the request is lost.

Optional Feature:
- Macro: IMEM_PERF_EN.
- When defined, adds outputs:
  - Fetch_count_o[31:0]: increments on every Valid_o.
  - Wait_count_o[31:0]: increments on every cycle with Stall_if_o=1.
  - Flush_count_o[15:0]: increments on every aborted fetch.
- Counter behaviour: all reset to 0, wrap modulo 2^width.
- When undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package/defines file:
  - the NOP constant (shared with the fetch stage);
  - FSM state encodings IMEM_IDLE=2'd0, IMEM_BUSY=2'd1, IMEM_RESP=2'd2.
- One natural sub-module: imem_ram, a single-port synchronous-read RAM with a separate write port (parameter DEPTH_LOG2).
- FSM and fault logic stay in imem_responder.

Test Plan:
- Load RAM[0]=32'h00500093, RAM[1]=32'h00A00113; Req_i with Pc_i=0, WAIT_STATES=2 -> Stall_if_o high 2 cycles, Valid_o on the 3rd cycle after acceptance with 32'h00500093; then Pc_i=4 -> 32'h00A00113.
- Pc_i=32'h00000002 -> Valid_o and Fault_o same cycle, Instruction_o=32'h00000013.
- Pc_i=32'h00001000 (DEPTH_LOG2=10) -> Fault_o pulse, Instruction_o=32'h00000013.
- Request Pc_i=8, assert Flush_i one cycle into BUSY -> IDLE next edge, no Valid_o, Instruction_o holds its previous value; new request Pc_i=0 accepted next cycle.
- Reset_n low mid-BUSY -> immediate Stall_if_o=0, Instruction_o=32'h00000013; RAM retains loaded data, verified by a subsequent fetch.
- Load_we_i writing word 3=32'hDEADBEEF in the same cycle RESP reads word 3 (old value 32'h00000013) -> response 32'h00000013; next fetch of Pc_i=12 returns 32'hDEADBEEF.
